// File: rtl/exe_mdu.sv
// ---------------------------------------------------------------------------
// exe_mdu : multiply/divide unit with architectural HI/LO registers.
//
// Sits beside the combinational ALU in EXE.  Multiplies (plain and
// accumulate/subtract) finish after MUL_LAT busy cycles.  Divides run one
// restoring iteration per cycle for WIDTH cycles, then spend one FIX cycle
// applying the signs before committing.  MTHI/MTLO write HI/LO directly at
// the accepting edge and never raise busy.
//
// Ports
//   clk      in  1      clock
//   resetn   in  1      synchronous active-low reset
//   start    in  1      operation request, sampled only while idle
//   mdu_op   in  4      operation code (11..15 behave as NOP)
//   src_a    in  WIDTH  multiplicand / dividend / MTHI-MTLO data
//   src_b    in  WIDTH  multiplier / divisor
//   flush    in  1      kill any in-flight operation
//   busy     out 1      operation in flight, EXE must stall
//   done     out 1      one-cycle pulse when new HI/LO first appear
//   hi       out WIDTH  HI register
//   lo       out WIDTH  LO register
// ---------------------------------------------------------------------------
module exe_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MUL_CNT0 = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT0 = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  // Two's-complement negate when neg is set; used both for taking operand
  // magnitudes and for restoring the result signs.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  // ---- request decode (IDLE only) ----
  logic in_valid, in_is_mul, in_is_div, in_is_mt, in_signed, accept;

  always_comb begin
    in_valid  = (mdu_op >= OP_MULT) && (mdu_op <= OP_MTLO);
    in_is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    in_is_mt  = (mdu_op == OP_MTHI) || (mdu_op == OP_MTLO);
    in_is_mul = in_valid && !in_is_div && !in_is_mt;
    in_signed = (mdu_op == OP_DIV);
    accept    = (state_q == S_IDLE) && start && !flush && in_valid;
  end

  // ---- multiply datapath ----
  // Operands are extended to 2*WIDTH (sign or zero) so one unsigned
  // multiply truncated to 2*WIDTH gives the right product for both kinds.
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, acc, mul_res;

  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ext_a      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod       = ext_a * ext_b;
    acc        = {hi_q, lo_q};
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  // ---- restoring divide step ----
  // rem_q always stays below the divisor, so the shifted partial remainder
  // fits in WIDTH+1 bits and the trial subtraction's top bit is its sign.
  logic [WIDTH:0]   rem_sh, trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, dvs_q};
    trial_ok = !trial[WIDTH];
    rem_nxt  = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt  = {quo_q[WIDTH-2:0], trial_ok};
  end

  // ---- sign fix-up and divide-by-zero override ----
  logic             div_signed, q_neg, r_neg, div_zero;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    div_signed = (op_q == OP_DIV);
    q_neg      = div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg      = div_signed && a_q[WIDTH-1];
    div_zero   = (b_q == '0);
    if (div_zero) begin
      q_fix = '1;
      r_fix = a_q;
    end else begin
      q_fix = cond_neg(quo_q, q_neg);
      r_fix = cond_neg(rem_q, r_neg);
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && in_is_mul)      state_d = S_MUL;
        else if (accept && in_is_div) state_d = S_DIV;
      end
      S_MUL:   if (flush || cnt_q == '0) state_d = S_IDLE;
      S_DIV: begin
        if (flush)              state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // ---- operand capture, iteration and HI/LO commit ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q  <= mdu_op;
            a_q   <= src_a;
            b_q   <= src_b;
            cnt_q <= in_is_div ? DIV_CNT0 : MUL_CNT0;
            rem_q <= '0;
            quo_q <= cond_neg(src_a, in_signed && src_a[WIDTH-1]);
            dvs_q <= cond_neg(src_b, in_signed && src_b[WIDTH-1]);
            if (mdu_op == OP_MTHI) begin
              hi_q   <= src_a;
              done_q <= 1'b1;
            end
            if (mdu_op == OP_MTLO) begin
              lo_q   <= src_a;
              done_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (!flush) begin
            if (cnt_q == '0) begin
              {hi_q, lo_q} <= mul_res;
              done_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        S_DIV: begin
          if (!flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi_q   <= r_fix;
            lo_q   <= q_fix;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
module tb_exe_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn, start, flush;
  logic [3:0]   mdu_op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  exe_mdu #(.WIDTH(W), .MUL_LAT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .mdu_op (mdu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, release the inputs, count busy cycles (bounded) and
  // check done in the first non-busy cycle.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int nb);
    start  = 1'b1;
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    tick();
    start  = 1'b0;
    mdu_op = 4'd0;
    src_a  = $urandom;
    src_b  = $urandom;
    nb = 0;
    while (busy && nb < 100) begin
      tick();
      nb++;
    end
    chk("done_pulse", done, 1);
  endtask

  int nb;
  logic [W-1:0] hi_s, lo_s;

  initial begin
    resetn = 1'b0; start = 1'b0; flush = 1'b0;
    mdu_op = 4'd0; src_a = '0; src_b = '0;
    repeat (3) tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    resetn = 1'b1;
    tick();

    // signed / unsigned multiply
    do_op(4'd1, 32'hFFFF_FFFE, 32'h0000_0003, nb);
    chk("mult_busy_cycles", nb, 2);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    tick();
    chk("mult_done_width", done, 0);
    do_op(4'd2, 32'hFFFF_FFFE, 32'h0000_0003, nb);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // division
    do_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, nb);
    chk("div_busy_cycles", nb, 33);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    do_op(4'd3, 32'h0000_0007, 32'hFFFF_FFFE, nb);
    chk("div_negb_lo", lo, 32'hFFFF_FFFD);
    chk("div_negb_hi", hi, 32'h0000_0001);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);
    do_op(4'd4, 32'h0000_0005, 32'h0000_0000, nb);
    chk("divu_z_busy", nb, 33);
    chk("divu_z_lo", lo, 32'hFFFF_FFFF);
    chk("divu_z_hi", hi, 32'h0000_0005);
    do_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0000, nb);
    chk("div_z_lo", lo, 32'hFFFF_FFFF);
    chk("div_z_hi", hi, 32'hFFFF_FFF9);
    do_op(4'd4, 32'hFFFF_FFFF, 32'h0000_0010, nb);
    chk("divu_big_lo", lo, 32'h0FFF_FFFF);
    chk("divu_big_hi", hi, 32'h0000_000F);

    // accumulate
    do_op(4'd9, 32'h0000_0000, 32'h0, nb);
    chk("mthi_busy", nb, 0);
    chk("mthi_hi", hi, 32'h0);
    do_op(4'd10, 32'hFFFF_FFFF, 32'h0, nb);
    chk("mtlo_lo", lo, 32'hFFFF_FFFF);
    do_op(4'd6, 32'h1, 32'h1, nb);
    chk("maddu_hi", hi, 32'h1);
    chk("maddu_lo", lo, 32'h0);
    do_op(4'd7, 32'h1, 32'h2, nb);
    chk("msub_hi", hi, 32'h0);
    chk("msub_lo", lo, 32'hFFFF_FFFE);

    // invalid op is ignored
    start = 1'b1; mdu_op = 4'd13; src_a = 32'h5555_5555; src_b = 32'h3;
    tick();
    start = 1'b0;
    chk("nop_busy", busy, 0);
    tick();
    chk("nop_done", done, 0);
    chk("nop_lo", lo, 32'hFFFF_FFFE);

    // flush mid-divide
    hi_s = hi; lo_s = lo;
    start = 1'b1; mdu_op = 4'd4; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    repeat (40) begin
      tick();
      if (done) chk("flush_late_done", done, 0);
    end
    chk("flush_hi", hi, hi_s);
    chk("flush_lo", lo, lo_s);

    // flush beats a simultaneous MTLO
    start = 1'b1; flush = 1'b1; mdu_op = 4'd10; src_a = 32'h1234;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_mt_done0", done, 0);
    tick();
    chk("flush_mt_done1", done, 0);
    chk("flush_mt_lo", lo, lo_s);

    // start held while busy, inputs changed mid-operation
    start = 1'b1; mdu_op = 4'd1; src_a = 32'd3; src_b = 32'd5;
    tick();
    mdu_op = 4'd6; src_a = 32'd2; src_b = 32'd3;
    nb = 0;
    while (busy && nb < 100) begin
      tick();
      nb++;
    end
    chk("held_mult_busy", nb, 2);
    chk("held_mult_done", done, 1);
    chk("held_mult_hi", hi, 32'h0);
    chk("held_mult_lo", lo, 32'd15);
    tick();
    start = 1'b0;
    chk("held_accept_busy", busy, 1);
    nb = 1;
    while (busy && nb < 100) begin
      tick();
      nb++;
    end
    chk("held_maddu_done", done, 1);
    chk("held_maddu_hi", hi, 32'h0);
    chk("held_maddu_lo", lo, 32'd21);

    // reset in the middle of a divide
    start = 1'b1; mdu_op = 4'd4; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rstdiv_hi", hi, 0);
    chk("rstdiv_lo", lo, 0);
    chk("rstdiv_busy", busy, 0);
    chk("rstdiv_done", done, 0);
    do_op(4'd4, 32'd100, 32'd7, nb);
    chk("divu_busy_cycles", nb, 33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
